// File: rtl/gh_uart_pkg.sv
// Shared definitions for the UART core datapath blocks.
// Holds the default data width and a constant-foldable ceil(log2) helper.
package gh_uart_pkg;

  localparam int UART_DATA_W = 8;

  // Returns ceil(log2(n)), with a floor of 1 so that a count port never collapses to zero bits.
  function automatic int gh_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      v = v >> 1;
      r++;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/gh_pipe_stage.sv
// One stage of the elastic register pipeline: a valid bit plus a data register.
// The data register only captures when a valid word arrives, so empty stages keep their last word.
module gh_pipe_stage
  import gh_uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             src_valid_i,
  input  logic [WIDTH-1:0] src_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = src_valid_i;
      if (src_valid_i) data_d = src_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/gh_register_pipe_ce.sv
// DEPTH-stage elastic register pipeline with valid/ready handshake, clock enable and flush.
// Ready propagates combinationally from out_ready back to in_ready so bubbles collapse at full rate.
module gh_register_pipe_ce
  import gh_uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = gh_clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CE,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q    [DEPTH];
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data  [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             clear;
  logic             in_xfer;
  logic             out_xfer;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A stage advances when it is empty or the stage after it is advancing.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = CE & (~valid_q[DEPTH-1] | out_ready);
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = CE & (~valid_q[i] | adv[i+1]);
    end
  end

  assign clear     = CE & flush;
  assign in_ready  = adv[0] & ~flush & ~rst;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = valid_q[DEPTH-1] & CE;
  assign out_xfer  = out_valid & out_ready;
  assign out_data  = data_q[DEPTH-1];

  assign src_valid[0] = in_xfer;
  assign src_data[0]  = in_data;

  for (genvar i = 1; i < DEPTH; i++) begin : g_src
    assign src_valid[i] = valid_q[i-1];
    assign src_data[i]  = data_q[i-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    gh_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (adv[i]),
      .clear_i    (clear),
      .src_valid_i(src_valid[i]),
      .src_data_i (src_data[i]),
      .valid_o    (valid_q[i]),
      .data_o     (data_q[i])
    );
  end

  // Occupancy tracks popcount(valid_q); simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
